// File: rtl/meas_frame_packer.sv
// Snapshots NUM_CH measurement words and frames them as HDR0, HDR1, payload MSB-first (+ checksum with FRAME_CKSUM_EN).
// Latency: tx_valid rises one cycle after the start edge; one byte per cycle with tx_ready high; frame_done LEN+1 cycles after start.
// Backpressure: tx_data/byte_idx hold while tx_valid & !tx_ready; frame_req outside IDLE is dropped, not queued.
module meas_frame_packer #(
  parameter int          NUM_CH      = 5,
  parameter int          CH_WIDTH    = 32,
  parameter logic [7:0]  HDR0        = 8'h55,
  parameter logic [7:0]  HDR1        = 8'hAA,
  parameter int          AUTO_REPEAT = 1
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic [NUM_CH*CH_WIDTH-1:0]   meas_data,
  input  logic                         frame_req,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic [7:0]                   byte_idx
);

  localparam int W   = NUM_CH * CH_WIDTH;
  localparam int PLD = W / 8;
`ifdef FRAME_CKSUM_EN
  localparam int LEN = PLD + 3;
`else
  localparam int LEN = PLD + 2;
`endif
  localparam int         SEL_W    = (PLD > 1) ? $clog2(PLD) : 1;
  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

  generate
    if (NUM_CH < 1 || (CH_WIDTH % 8) != 0 || CH_WIDTH < 8) begin : g_bad_geometry
      $error("meas_frame_packer: NUM_CH must be >= 1 and CH_WIDTH a non-zero multiple of 8");
    end
    if (LEN > 256) begin : g_bad_len
      $error("meas_frame_packer: frame length exceeds 256 bytes");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              byte_idx_q;
  logic [PLD-1:0][7:0]     shadow_q;
  logic [7:0]              pld_byte;
  logic                    start;
  logic                    hs;
  logic                    last;

  // Byte 2 maps to the most significant shadow byte, so index downward from PLD-1.
  assign pld_byte = shadow_q[SEL_W'(PLD + 1 - int'(byte_idx_q))];
  assign hs       = (state_q == SEND) && tx_ready;
  assign last     = (byte_idx_q == LAST_IDX);
  assign byte_idx = byte_idx_q;

`ifdef FRAME_CKSUM_EN
  logic [7:0] cksum_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cksum_q <= 8'd0;
    end else if (start) begin
      cksum_q <= 8'd0;
    end else if (hs && byte_idx_q >= 8'd2 && byte_idx_q <= 8'(PLD + 1)) begin
      cksum_q <= cksum_q + pld_byte;
    end
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_idx_q <= 8'd0;
      shadow_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        shadow_q   <= meas_data;
        byte_idx_q <= 8'd0;
      end else if (hs && !last) begin
        byte_idx_q <= byte_idx_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'd0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_req || AUTO_REPEAT != 0) begin
          start   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (byte_idx_q == 8'd0) begin
          tx_data = HDR0;
        end else if (byte_idx_q == 8'd1) begin
          tx_data = HDR1;
`ifdef FRAME_CKSUM_EN
        end else if (last) begin
          tx_data = cksum_q;
`endif
        end else begin
          tx_data = pld_byte;
        end
        if (hs && last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_meas_frame_packer.sv
// Bench for meas_frame_packer: four parameterisations share stimulus; a frame-level model checks the selected one every cycle.
module tb_meas_frame_packer;

`ifdef FRAME_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic         sys_clk = 1'b0;
  logic         rst = 1'b1;
  logic         frame_req = 1'b0;
  logic         tx_ready = 1'b1;
  logic [159:0] meas = '0;

  logic [7:0] td [4];
  logic [7:0] bi [4];
  logic       tv [4];
  logic       bz [4];
  logic       fd [4];

  always #5 sys_clk = ~sys_clk;

  meas_frame_packer #(.NUM_CH(5), .CH_WIDTH(32), .HDR0(8'h55), .HDR1(8'hAA), .AUTO_REPEAT(0)) dut_a (
    .sys_clk(sys_clk), .rst(rst), .meas_data(meas), .frame_req(frame_req),
    .tx_data(td[0]), .tx_valid(tv[0]), .tx_ready(tx_ready), .busy(bz[0]),
    .frame_done(fd[0]), .byte_idx(bi[0]));

  meas_frame_packer #(.NUM_CH(5), .CH_WIDTH(32), .HDR0(8'h55), .HDR1(8'hAA), .AUTO_REPEAT(1)) dut_b (
    .sys_clk(sys_clk), .rst(rst), .meas_data(meas), .frame_req(frame_req),
    .tx_data(td[1]), .tx_valid(tv[1]), .tx_ready(tx_ready), .busy(bz[1]),
    .frame_done(fd[1]), .byte_idx(bi[1]));

  meas_frame_packer #(.NUM_CH(1), .CH_WIDTH(8), .HDR0(8'h55), .HDR1(8'hAA), .AUTO_REPEAT(0)) dut_c (
    .sys_clk(sys_clk), .rst(rst), .meas_data(meas[159:152]), .frame_req(frame_req),
    .tx_data(td[2]), .tx_valid(tv[2]), .tx_ready(tx_ready), .busy(bz[2]),
    .frame_done(fd[2]), .byte_idx(bi[2]));

  meas_frame_packer #(.NUM_CH(3), .CH_WIDTH(16), .HDR0(8'h55), .HDR1(8'hAA), .AUTO_REPEAT(0)) dut_d (
    .sys_clk(sys_clk), .rst(rst), .meas_data(meas[159:112]), .frame_req(frame_req),
    .tx_data(td[3]), .tx_valid(tv[3]), .tx_ready(tx_ready), .busy(bz[3]),
    .frame_done(fd[3]), .byte_idx(bi[3]));

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int pld_of(input int s);
    case (s)
      0, 1:    return 20;
      2:       return 1;
      default: return 6;
    endcase
  endfunction

  function automatic int len_of(input int s);
    return pld_of(s) + 2 + CK;
  endfunction

  // Frame-level model: a frame is a byte list built from meas at its start edge.
  int         sel = 0;
  int         m_sel = 0;
  bit         m_active = 0;
  bit         m_done = 0;
  int         m_idx = 0;
  logic [7:0] m_frame [$];
  logic [7:0] acc_q [$];
  int         cyc = 0;
  int         start_edge = 0;
  int         done_edge = 0;
  int         frames = 0;
  bit         hs_last = 0;
  bit         bp_mode = 0;
  int         stall = 0;

  initial begin
    forever begin
      @(posedge sys_clk);
      cyc++;
      hs_last = 0;
      if (rst) begin
        m_sel    = sel;
        m_active = 0;
        m_done   = 0;
        m_idx    = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (!m_active) begin
        if (frame_req || m_sel == 1) begin
          logic [7:0] sum;
          sum = 8'd0;
          m_frame.delete();
          m_frame.push_back(8'h55);
          m_frame.push_back(8'hAA);
          for (int k = 0; k < pld_of(m_sel); k++) begin
            m_frame.push_back(meas[159 - 8*k -: 8]);
            sum = sum + meas[159 - 8*k -: 8];
          end
          if (CK != 0) m_frame.push_back(sum);
          m_active   = 1;
          m_idx      = 0;
          start_edge = cyc;
        end
      end else if (tx_ready) begin
        hs_last = 1;
        acc_q.push_back(m_frame[m_idx]);
        if (m_idx == len_of(m_sel) - 1) begin
          m_active  = 0;
          m_done    = 1;
          done_edge = cyc;
          frames++;
        end else begin
          m_idx++;
        end
      end

      @(negedge sys_clk);
      check("tx_valid", 64'(tv[m_sel]), 64'(m_active));
      check("tx_data", 64'(td[m_sel]), m_active ? 64'(m_frame[m_idx]) : 64'd0);
      check("byte_idx", 64'(bi[m_sel]), 64'(m_idx));
      check("busy", 64'(bz[m_sel]), 64'(m_active | m_done));
      check("frame_done", 64'(fd[m_sel]), 64'(m_done));

      // Backpressure: ready low for three cycles after every accepted byte.
      if (bp_mode) begin
        if (hs_last) stall = 3;
        if (stall > 0) begin
          tx_ready = 1'b0;
          stall--;
        end else begin
          tx_ready = 1'b1;
        end
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  task automatic do_reset(input int s);
    @(negedge sys_clk);
    sel = s;
    rst = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
  endtask

  task automatic pulse_req();
    @(negedge sys_clk);
    frame_req = 1'b1;
    @(negedge sys_clk);
    frame_req = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string nm);
    int t;
    t = 0;
    while (frames < n && t < budget) begin
      @(negedge sys_clk);
      t++;
    end
    check(nm, 64'(frames >= n), 64'd1);
  endtask

  task automatic wait_idx(input int v, input string nm);
    int t;
    t = 0;
    while (!(tv[0] && bi[0] == 8'(v)) && t < 100) begin
      @(negedge sys_clk);
      t++;
    end
    check(nm, 64'(bi[0]), 64'(v));
  endtask

  logic [7:0] ref_q [$];
  int         f0;
  int         d1;

  initial begin
    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_tx_valid", 64'(tv[0]), 64'd0);
    check("rst_busy", 64'(bz[0]), 64'd0);
    check("rst_byte_idx", 64'(bi[0]), 64'd0);
    check("rst_tx_data", 64'(td[0]), 64'd0);
    check("rst_frame_done", 64'(fd[0]), 64'd0);
    rst = 1'b0;

    // Basic frame
    meas = {32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'h01020304};
    acc_q.delete();
    f0 = frames;
    pulse_req();
    wait_frames(f0 + 1, 100, "basic_timeout");
    check("basic_len", 64'(acc_q.size()), 64'(22 + CK));
    check("basic_b0", 64'(acc_q[0]), 64'h55);
    check("basic_b1", 64'(acc_q[1]), 64'hAA);
    check("basic_b2", 64'(acc_q[2]), 64'h11);
    check("basic_b9", 64'(acc_q[9]), 64'h88);
    check("basic_b21", 64'(acc_q[21]), 64'h04);
    // frame_done is first sampled high at the 23rd edge after the start edge
    check("basic_done_lat", 64'(done_edge + 1 - start_edge), 64'(23 + CK));
    repeat (2) @(negedge sys_clk);
    check("basic_busy_after", 64'(bz[0]), 64'd0);
    check("basic_valid_after", 64'(tv[0]), 64'd0);
    ref_q = acc_q;

    // Backpressure
    acc_q.delete();
    bp_mode = 1;
    pulse_req();
    wait_frames(f0 + 2, 400, "bp_timeout");
    bp_mode = 0;
    check("bp_handshakes", 64'(acc_q.size()), 64'(22 + CK));
    for (int i = 0; i < 22 + CK; i++) check("bp_byte", 64'(acc_q[i]), 64'(ref_q[i]));
    check("bp_duration", 64'(done_edge - start_edge), 64'(1 + 4 * (21 + CK)));

    // Ignored request mid-frame, then reset mid-frame
    acc_q.delete();
    pulse_req();
    wait_idx(7, "ign_reach7");
    frame_req = 1'b1;
    @(negedge sys_clk);
    frame_req = 1'b0;
    wait_idx(10, "ign_reach10");
    rst = 1'b1;
    @(negedge sys_clk);
    check("midrst_tx_valid", 64'(tv[0]), 64'd0);
    check("midrst_busy", 64'(bz[0]), 64'd0);
    check("midrst_byte_idx", 64'(bi[0]), 64'd0);
    check("midrst_accepted", 64'(acc_q.size()), 64'd10);
    rst = 1'b0;
    acc_q.delete();
    f0 = frames;
    pulse_req();
    wait_frames(f0 + 1, 100, "fresh_timeout");
    check("fresh_len", 64'(acc_q.size()), 64'(22 + CK));
    check("fresh_b0", 64'(acc_q[0]), 64'h55);
    check("fresh_b2", 64'(acc_q[2]), 64'h11);

    // Snapshot coherency with AUTO_REPEAT
    f0 = frames;
    acc_q.delete();
    do_reset(1);
    @(negedge sys_clk);
    meas = '1;
    wait_frames(f0 + 1, 100, "coh1_timeout");
    check("coh1_b2", 64'(acc_q[2]), 64'h11);
    check("coh1_b21", 64'(acc_q[21]), 64'h04);
    d1 = done_edge;
    acc_q.delete();
    wait_frames(f0 + 2, 100, "coh2_timeout");
    check("coh2_gap", 64'(start_edge - d1), 64'd2);
    check("coh2_b0", 64'(acc_q[0]), 64'h55);
    check("coh2_b2", 64'(acc_q[2]), 64'hFF);
    check("coh2_b21", 64'(acc_q[21]), 64'hFF);

    // NUM_CH=1, CH_WIDTH=8
    do_reset(2);
    meas = '0;
    meas[159:152] = 8'h5A;
    acc_q.delete();
    f0 = frames;
    pulse_req();
    wait_frames(f0 + 1, 50, "small_timeout");
    check("small_len", 64'(acc_q.size()), 64'(3 + CK));
    check("small_b0", 64'(acc_q[0]), 64'h55);
    check("small_b1", 64'(acc_q[1]), 64'hAA);
    check("small_b2", 64'(acc_q[2]), 64'h5A);
    check("small_done_lat", 64'(done_edge + 1 - start_edge), 64'(4 + CK));

    // NUM_CH=3, CH_WIDTH=16
    do_reset(3);
    meas[159:112] = 48'h1234_5678_9ABC;
    acc_q.delete();
    f0 = frames;
    pulse_req();
    wait_frames(f0 + 1, 50, "w16_timeout");
    check("w16_len", 64'(acc_q.size()), 64'(8 + CK));
    check("w16_b2", 64'(acc_q[2]), 64'h12);
    check("w16_b3", 64'(acc_q[3]), 64'h34);
    check("w16_b7", 64'(acc_q[7]), 64'hBC);

`ifdef FRAME_CKSUM_EN
    do_reset(0);
    meas = {20{8'h10}};
    acc_q.delete();
    f0 = frames;
    pulse_req();
    wait_frames(f0 + 1, 100, "ck10_timeout");
    check("ck10_len", 64'(acc_q.size()), 64'd23);
    check("ck10_sum", 64'(acc_q[22]), 64'h40);
    meas = {20{8'hFF}};
    acc_q.delete();
    pulse_req();
    wait_frames(f0 + 2, 100, "ckff_timeout");
    check("ckff_sum", 64'(acc_q[22]), 64'hEC);
`endif

    repeat (2) @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
